x_feed_ctrl: RTL and testbench

- Sequences a bank of ROWS X_REG parallel-shift registers that feed the left edge of the systolic array.
- Load phase: accepts a row-major operand stream over a valid/ready handshake and writes each element into its row register at an absolute index.
- Drain phase: issues staggered shift enables so that row r starts emitting r cycles after row 0, which produces the diagonal input skew the array requires.
- Also flushes stale register contents after reset.

---
 rtl/x_feed_ctrl_pkg.sv | 30 +++
 rtl/x_feed_ctrl_if.sv | 44 ++++
 rtl/x_feed_ctrl_x_skew_gen.sv | 47 ++++
 rtl/x_feed_ctrl.sv | 177 +++++++++++++++++
 tb/tb_x_feed_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/x_feed_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : x_feed_pkg
// Purpose : Shared state encoding and width constants for the X_REG feed
//           controller (left-edge operand sequencer of the systolic array).
// Revision: 1.0 - initial release
// ============================================================================
package x_feed_pkg;

  // Default array geometry
  localparam int ROWS_DEF  = 8;
  localparam int DEPTH_DEF = 32;
  localparam int DW_DEF    = 8;

  // Derived widths: element index, drain counter and the LEN port
  localparam int IDX_W = $clog2(DEPTH_DEF);
  localparam int T_W   = $clog2(DEPTH_DEF + ROWS_DEF);
  localparam int LEN_W = 6;

  // Controller states; FLUSH is the post-reset state
  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage : x_feed_pkg
`default_nettype wire

// File: rtl/x_feed_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : x_feed_ctrl_if
// Purpose   : Job control, operand stream and X_REG bank control signals of
//             the feed controller. The controller uses the slave view.
// Revision  : 1.0 - initial release
// ============================================================================
interface x_feed_ctrl_if
  import x_feed_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int DW   = DW_DEF
);

  // Job control
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;

  // Operand stream
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;

  // X_REG bank control
  logic [ROWS-1:0]  reg_en;
  logic             reg_write;
  logic [IDX_W-1:0] reg_idx;
  logic [DW-1:0]    reg_din;
  logic [ROWS-1:0]  out_valid;

  modport master (
    output start, len, s_valid, s_data,
    input  busy, done, s_ready, reg_en, reg_write, reg_idx, reg_din, out_valid
  );

  modport slave (
    input  start, len, s_valid, s_data,
    output busy, done, s_ready, reg_en, reg_write, reg_idx, reg_din, out_valid
  );

endinterface : x_feed_ctrl_if
`default_nettype wire

// File: rtl/x_feed_ctrl_x_skew_gen.sv
`default_nettype none
// ============================================================================
// Module  : x_skew_gen
// Purpose : Drain-phase window generator. Row r is shifted while
//           r <= t < r + Leff, which skews each row one cycle behind the
//           previous one. OUT_VALID follows the window by one cycle because
//           the X_REG output is registered.
// Revision: 1.0 - initial release
// ============================================================================
module x_skew_gen
  import x_feed_pkg::*;
#(
  parameter int ROWS = ROWS_DEF
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic [T_W-1:0]   t_i,         // drain counter of the cycle being prepared
  input  wire logic [LEN_W-1:0] leff_i,      // effective row length of the job
  input  wire logic             active_i,    // prepared cycle is a drain cycle
  output logic      [ROWS-1:0]  en_mask_o,   // shift enables for the prepared cycle
  output logic      [ROWS-1:0]  out_valid_o  // registered fresh-operand flags
);

  logic [ROWS-1:0] w_window;
  logic [ROWS-1:0] win_q;
  logic [ROWS-1:0] ov_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign w_window[r] = (int'(t_i) >= r) && (int'(t_i) < r + int'(leff_i));
  end

  assign en_mask_o   = active_i ? w_window : '0;
  assign out_valid_o = ov_q;

  // Track the enables that are live this cycle and delay them by one for OUT_VALID
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= '0;
      ov_q  <= '0;
    end else begin
      win_q <= en_mask_o;
      ov_q  <= win_q;
    end
  end

endmodule : x_skew_gen
`default_nettype wire

// File: rtl/x_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : x_feed_ctrl
// Purpose : Sequencer for the bank of X_REG shift registers at the left edge
//           of the systolic array: post-reset flush, row-major load from a
//           valid/ready stream, and skewed drain.
// Revision: 1.0 - initial release
// ============================================================================
module x_feed_ctrl
  import x_feed_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  wire logic    clk_i,
  input  wire logic    rst_ni,
  x_feed_ctrl_if.slave feed_if
);

  localparam int               ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int               FL_W     = $clog2(DEPTH + 1);
  localparam int               ROWS_M2  = ROWS - 2;
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [FL_W-1:0]  FL_END   = FL_W'(DEPTH);

  state_e           state_q;
  logic [FL_W-1:0]  fl_q;
  logic [ROW_W-1:0] row_q;
  logic [IDX_W-1:0] idx_q;
  logic [T_W-1:0]   t_q;
  logic [LEN_W-1:0] leff_q;
  logic             last_q;     // final write of the load is on the bus
  logic             s_ready_q;
  logic [ROWS-1:0]  reg_en_q;
  logic             reg_write_q;
  logic [IDX_W-1:0] reg_idx_q;
  logic [DW-1:0]    reg_din_q;
  logic             busy_q;
  logic             done_q;

  logic [LEN_W-1:0] w_leff;
  logic [T_W-1:0]   w_t_last;
  logic [T_W-1:0]   w_t_nxt;
  logic             w_drain_nxt;
  logic             w_hs;
  logic             w_idx_wrap;
  logic             w_hs_last;
  logic [ROWS-1:0]  w_en_mask;
  logic [ROWS-1:0]  w_out_valid;

  // Job length is clamped to the register depth
  assign w_leff     = (feed_if.len > DEPTH_L) ? DEPTH_L : feed_if.len;
  // Last drain cycle index: Leff + ROWS - 2
  assign w_t_last   = T_W'(int'(leff_q) + ROWS_M2);
  assign w_hs       = feed_if.s_valid & s_ready_q;
  assign w_idx_wrap = (idx_q == IDX_W'(leff_q - LEN_W'(1)));
  assign w_hs_last  = (row_q == ROW_LAST) && w_idx_wrap;

  // The drain window is computed for the cycle being prepared so it can be registered
  assign w_drain_nxt = ((state_q == ST_LOAD)  && last_q) ||
                       ((state_q == ST_DRAIN) && (t_q != w_t_last));
  assign w_t_nxt     = (state_q == ST_DRAIN) ? (t_q + T_W'(1)) : '0;

  x_skew_gen #(
    .ROWS (ROWS)
  ) u_skew (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .t_i         (w_t_nxt),
    .leff_i      (leff_q),
    .active_i    (w_drain_nxt),
    .en_mask_o   (w_en_mask),
    .out_valid_o (w_out_valid)
  );

  // Controller state, counters and registered bank controls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_FLUSH;
      fl_q        <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      t_q         <= '0;
      leff_q      <= '0;
      last_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      reg_en_q    <= '0;
      reg_write_q <= 1'b0;
      reg_idx_q   <= '0;
      reg_din_q   <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      reg_en_q    <= w_en_mask;
      case (state_q)
        ST_FLUSH: begin
          // Shift zeros through every row DEPTH times; X_REG has no reset
          if (fl_q != FL_END) begin
            reg_en_q <= '1;
            fl_q     <= fl_q + FL_W'(1);
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (feed_if.start) begin
            leff_q <= w_leff;
            row_q  <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            busy_q <= 1'b1;
            if (w_leff == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_LOAD;
              s_ready_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (last_q) begin
            state_q <= ST_DRAIN;
            t_q     <= '0;
            last_q  <= 1'b0;
          end else if (w_hs) begin
            reg_en_q    <= ROWS'(1) << row_q;
            reg_write_q <= 1'b1;
            reg_idx_q   <= idx_q;
            reg_din_q   <= feed_if.s_data;
            if (w_hs_last) begin
              s_ready_q <= 1'b0;
              last_q    <= 1'b1;
            end else if (w_idx_wrap) begin
              idx_q <= '0;
              row_q <= row_q + ROW_W'(1);
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (t_q == w_t_last) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
          end else begin
            t_q <= w_t_nxt;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign feed_if.s_ready   = s_ready_q;
  assign feed_if.reg_en    = reg_en_q;
  assign feed_if.reg_write = reg_write_q;
  assign feed_if.reg_idx   = reg_idx_q;
  assign feed_if.reg_din   = reg_din_q;
  assign feed_if.out_valid = w_out_valid;
  assign feed_if.busy      = busy_q;
  assign feed_if.done      = done_q;

endmodule : x_feed_ctrl
`default_nettype wire

// File: tb/tb_x_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_x_feed_ctrl
// Purpose : Self-checking bench for x_feed_ctrl with a behavioural X_REG bank,
//           a write/operand scoreboard and a table of load/drain jobs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_x_feed_ctrl;
  import x_feed_pkg::*;

  localparam int ROWS  = 4;
  localparam int DEPTH = 32;
  localparam int DW    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  x_feed_ctrl_if #(.ROWS(ROWS), .DW(DW)) fif ();

  x_feed_ctrl #(.ROWS(ROWS), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .feed_if (fif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural X_REG bank: write at IDX, or shift position 0 out to DOUT with zero fill
  logic [DW-1:0] mem  [ROWS][DEPTH] = '{default: '{default: 8'hEE}};
  logic [DW-1:0] dout [ROWS]        = '{default: 8'h00};

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (fif.reg_en[r]) begin
        if (fif.reg_write) begin
          mem[r][fif.reg_idx] <= fif.reg_din;
        end else begin
          dout[r] <= mem[r][0];
          for (int i = 0; i < DEPTH - 1; i++) mem[r][i] <= mem[r][i+1];
          mem[r][DEPTH-1] <= '0;
        end
      end
    end
  end

  // Scoreboard: expected writes and expected per-row operands
  typedef struct {
    int            row;
    int            idx;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wq [$];
  logic [DW-1:0] dq [ROWS][$];
  int            max_idx;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fif.reg_write) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", 64'(fif.reg_en), 64'(0));
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_en",  64'(fif.reg_en),  64'(1) << e.row);
          chk("wr_idx", 64'(fif.reg_idx), 64'(e.idx));
          chk("wr_din", 64'(fif.reg_din), 64'(e.data));
          if (int'(fif.reg_idx) > max_idx) max_idx = int'(fif.reg_idx);
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        if (fif.out_valid[r]) begin
          if (dq[r].size() == 0) chk("ov_unexpected_row", 64'(r), 64'(ROWS));
          else                   chk("dout", 64'(dout[r]), 64'(dq[r].pop_front()));
        end
      end
    end
  end

  function automatic logic [ROWS-1:0] win(input int t, input int leff);
    logic [ROWS-1:0] m;
    for (int r = 0; r < ROWS; r++) m[r] = (t >= r) && (t < r + leff);
    return m;
  endfunction

  task automatic mem_zero_check(input string name);
    int nz;
    nz = 0;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < DEPTH; i++)
        if (mem[r][i] != '0) nz++;
    chk(name, 64'(nz), 64'(0));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (fif.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 64'(fif.busy), 64'(0));
  endtask

  // Called at the negedge where reset is released
  task automatic flush_check();
    int good, bad;
    good = 0;
    bad  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!fif.busy) break;
      if (fif.reg_en == '1 && !fif.reg_write && fif.out_valid == '0) good++;
      else bad++;
    end
    chk("flush_cycles", 64'(good), 64'(32));
    chk("flush_bad", 64'(bad), 64'(0));
    chk("flush_to_idle", 64'(fif.busy), 64'(0));
    chk("flush_end_en", 64'(fif.reg_en), 64'(0));
    mem_zero_check("flush_mem_zero");
  endtask

  function automatic logic [DW-1:0] elem(input int k, input int j);
    return DW'(k + 1 + j * 37);
  endfunction

  // Table-driven jobs: inputs and expected outputs
  typedef struct {
    int len;
    bit stall;
    int exp_leff;
    int exp_last_idx;
    int exp_drain;
  } job_t;

  job_t jobs [5];

  task automatic run_job(input job_t jb, input int j);
    int n, k, cyc;
    bit tog;
    wait_idle();
    max_idx      = -1;
    fif.start    = 1'b1;
    fif.len      = LEN_W'(jb.len);
    @(negedge clk);
    fif.start    = 1'b0;
    chk("s_ready_load", 64'(fif.s_ready), 64'(1));
    n   = ROWS * jb.exp_leff;
    k   = 0;
    cyc = 0;
    tog = 1'b1;
    while (k < n && cyc < 5000) begin
      fif.s_valid = jb.stall ? tog : 1'b1;
      tog         = ~tog;
      fif.s_data  = elem(k, j);
      // START during LOAD must be ignored
      fif.start   = jb.stall && (cyc == 1);
      fif.len     = '0;
      if (fif.s_valid && fif.s_ready) begin
        wq.push_back('{row: k / jb.exp_leff, idx: k % jb.exp_leff, data: elem(k, j)});
        dq[k / jb.exp_leff].push_back(elem(k, j));
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    fif.s_valid = 1'b0;
    fif.start   = 1'b0;
    chk("stream_done", 64'(k), 64'(n));
    chk("s_ready_drop", 64'(fif.s_ready), 64'(0));
    for (int t = 0; t < jb.exp_drain; t++) begin
      @(negedge clk);
      chk("drain_en", 64'({fif.reg_write, fif.reg_en}), 64'({1'b0, win(t, jb.exp_leff)}));
      chk("drain_ov", 64'(fif.out_valid), 64'((t == 0) ? '0 : win(t - 1, jb.exp_leff)));
      chk("drain_done_low", 64'(fif.done), 64'(0));
    end
    @(negedge clk);
    chk("fin_done", 64'(fif.done), 64'(1));
    chk("fin_ov", 64'(fif.out_valid), 64'(win(jb.exp_drain - 1, jb.exp_leff)));
    chk("fin_en", 64'(fif.reg_en), 64'(0));
    @(negedge clk);
    chk("post_done", 64'({fif.done, fif.busy}), 64'(0));
    chk("last_idx", 64'(max_idx), 64'(jb.exp_last_idx));
    chk("wq_empty", 64'(wq.size()), 64'(0));
    for (int r = 0; r < ROWS; r++) chk("dq_empty", 64'(dq[r].size()), 64'(0));
    mem_zero_check("job_mem_zero");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t j2;
    int   k;

    jobs[0] = '{len: 3,  stall: 1'b0, exp_leff: 3,  exp_last_idx: 2,  exp_drain: 6};
    jobs[1] = '{len: 3,  stall: 1'b1, exp_leff: 3,  exp_last_idx: 2,  exp_drain: 6};
    jobs[2] = '{len: 40, stall: 1'b0, exp_leff: 32, exp_last_idx: 31, exp_drain: 35};
    jobs[3] = '{len: 1,  stall: 1'b0, exp_leff: 1,  exp_last_idx: 0,  exp_drain: 4};
    jobs[4] = '{len: 5,  stall: 1'b1, exp_leff: 5,  exp_last_idx: 4,  exp_drain: 8};

    fif.start   = 1'b0;
    fif.len     = '0;
    fif.s_valid = 1'b0;
    fif.s_data  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy",    64'(fif.busy),      64'(1));
    chk("rst_s_ready", 64'(fif.s_ready),   64'(0));
    chk("rst_reg_en",  64'(fif.reg_en),    64'(0));
    chk("rst_write",   64'(fif.reg_write), 64'(0));
    chk("rst_idx_din", 64'({fif.reg_idx, fif.reg_din}), 64'(0));
    chk("rst_ov_done", 64'({fif.out_valid, fif.done}), 64'(0));
    rst_n = 1'b1;
    flush_check();

    for (int j = 0; j < 5; j++) run_job(jobs[j], j);

    // LEN=0: DONE in the cycle after START; no stream accepted even with S_VALID high
    wait_idle();
    fif.start   = 1'b1;
    fif.len     = '0;
    fif.s_valid = 1'b1;
    @(negedge clk);
    fif.start = 1'b0;
    chk("len0_done",    64'(fif.done),    64'(1));
    chk("len0_busy",    64'(fif.busy),    64'(1));
    chk("len0_s_ready", 64'(fif.s_ready), 64'(0));
    chk("len0_en",      64'(fif.reg_en),  64'(0));
    @(negedge clk);
    chk("len0_after", 64'({fif.done, fif.busy, fif.s_ready, fif.reg_en}), 64'(0));
    fif.s_valid = 1'b0;

    // Reset mid-load after 5 handshakes
    wait_idle();
    fif.start = 1'b1;
    fif.len   = 6'd3;
    @(negedge clk);
    fif.start = 1'b0;
    k = 0;
    for (int c = 0; c < 50 && k < 5; c++) begin
      fif.s_valid = 1'b1;
      fif.s_data  = DW'(8'hA0 + k);
      if (fif.s_ready) begin
        wq.push_back('{row: k / 3, idx: k % 3, data: DW'(8'hA0 + k)});
        k++;
      end
      @(negedge clk);
    end
    fif.s_valid = 1'b0;
    chk("abort_hs", 64'(k), 64'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_clear", 64'({fif.s_ready, fif.reg_en, fif.reg_write, fif.out_valid, fif.done}), 64'(0));
    chk("abort_busy", 64'(fif.busy), 64'(1));
    chk("abort_wq", 64'(wq.size()), 64'(0));
    wq.delete();
    for (int r = 0; r < ROWS; r++) dq[r].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush_check();
    j2 = '{len: 2, stall: 1'b0, exp_leff: 2, exp_last_idx: 1, exp_drain: 5};
    run_job(j2, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_x_feed_ctrl
`default_nettype wire
